ws2812_serializer: RTL and testbench

//  Downstream stage of the racer core: walks current_led over the strip, samples the GRB

---
 rtl/ws2812_serializer.sv | 150 +++++++++++++++
 tb/tb_ws2812_serializer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_serializer.sv
// WS2812 one-wire NRZ serialiser: walks current_led over the strip and streams GRB words MSB first.
// Build macro WS2812_DIM_EN: each captured channel is right-shifted by DIM_SHIFT before sending.
module ws2812_serializer #(
   parameter int MAX_POS       = 16,
   parameter int T0H_CYCLES    = 20,
   parameter int T1H_CYCLES    = 40,
   parameter int BIT_CYCLES    = 62,
   parameter int LATCH_CYCLES  = 15000,
   parameter int LOOKUP_CYCLES = 2,
   parameter int DIM_SHIFT     = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       update_frame,
   input  logic [7:0]                 led_green_intensity,
   input  logic [7:0]                 led_red_intensity,
   input  logic [7:0]                 led_blue_intensity,
   output logic [$clog2(MAX_POS)-1:0] current_led,
   output logic                       data_out,
   output logic                       busy,
   output logic                       frame_done
);
   localparam int LED_W     = $clog2(MAX_POS);
   localparam int CNT_MAX_A = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > LOOKUP_CYCLES) ? CNT_MAX_A : LOOKUP_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [LED_W-1:0] LAST_LED = LED_W'(MAX_POS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SEND  = 2'd2;
   localparam logic [1:0] ST_LATCH = 2'd3;

   if (BIT_CYCLES <= T1H_CYCLES || T0H_CYCLES < 1 || LOOKUP_CYCLES < 1 ||
       DIM_SHIFT < 0 || DIM_SHIFT > 7) begin : g_bad_params
      $error("ws2812_serializer: inconsistent timing or DIM_SHIFT parameters");
   end

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt, cnt_inc, high_len;
   logic [4:0]       bit_idx;
   logic [LED_W-1:0] led_pos;
   logic             pending;
   logic [23:0]      shreg, prefetch, word;
   logic             load_done, bit_start, bit_end, last_led;

   function automatic logic [7:0] chan(input logic [7:0] v);
`ifdef WS2812_DIM_EN
      chan = v >> DIM_SHIFT;
`else
      chan = v;
`endif
   endfunction

   assign word      = {chan(led_green_intensity), chan(led_red_intensity), chan(led_blue_intensity)};
   assign cnt_inc   = cnt + CNT_W'(1);
   assign high_len  = shreg[23] ? CNT_W'(T1H_CYCLES) : CNT_W'(T0H_CYCLES);
   assign load_done = (state == ST_LOAD) && (cnt == CNT_W'(LOOKUP_CYCLES - 1));
   assign bit_start = (state == ST_SEND) && (cnt == '0);
   assign bit_end   = (state == ST_SEND) && (cnt == CNT_W'(BIT_CYCLES - 1));
   assign last_led  = (led_pos == LAST_LED);

   // Word registers: prefetch is sampled at bit 0 so LED boundaries cost no cycles
   always_ff @(posedge clk) begin
      if (load_done)
         shreg <= word;
      else if (bit_end)
         shreg <= (bit_idx == 5'd0) ? prefetch : {shreg[22:0], 1'b0};
      if (bit_start && bit_idx == 5'd0 && !last_led)
         prefetch <= word;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         led_pos     <= '0;
         current_led <= '0;
         pending     <= 1'b0;
         data_out    <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (busy && update_frame)
            pending <= 1'b1;
         case (state)
            ST_IDLE: begin
               current_led <= '0;
               led_pos     <= '0;
               cnt         <= '0;
               if (update_frame) begin
                  state <= ST_LOAD;
                  busy  <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (load_done) begin
                  cnt      <= '0;
                  bit_idx  <= 5'd23;
                  data_out <= 1'b1;
                  state    <= ST_SEND;
               end else
                  cnt <= cnt_inc;
            end
            ST_SEND: begin
               // Advance the core's index one LED ahead; it has ~23 bit periods to settle
               if (bit_start && bit_idx == 5'd23 && !last_led)
                  current_led <= led_pos + LED_W'(1);
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx != 5'd0) begin
                     bit_idx  <= bit_idx - 5'd1;
                     data_out <= 1'b1;
                  end else if (!last_led) begin
                     bit_idx  <= 5'd23;
                     led_pos  <= led_pos + LED_W'(1);
                     data_out <= 1'b1;
                  end else begin
                     data_out    <= 1'b0;
                     current_led <= '0;
                     led_pos     <= '0;
                     state       <= ST_LATCH;
                  end
               end else begin
                  cnt      <= cnt_inc;
                  data_out <= (cnt_inc < high_len);
               end
            end
            ST_LATCH: begin
               data_out <= 1'b0;
               if (cnt == CNT_W'(LATCH_CYCLES - 1)) begin
                  cnt        <= '0;
                  frame_done <= 1'b1;
                  pending    <= 1'b0;
                  if (pending || update_frame)
                     state <= ST_LOAD;
                  else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else
                  cnt <= cnt_inc;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ws2812_serializer.sv
// Directed bench for ws2812_serializer: decodes data_out back into bits and checks timing/content.
// Build macro WS2812_DIM_EN selects the dimmed expected words.
module tb_ws2812_serializer;
   localparam int MAX_POS = 4, T0H = 2, T1H = 4, BITC = 6, LATCH = 10, LOOKUP = 2;
   localparam int FRAME_LEN = MAX_POS * 24 * BITC + LATCH;           // first rise -> frame_done
   localparam int DONE_GAP  = LOOKUP + MAX_POS * 24 * BITC + LATCH;  // frame_done -> frame_done

`ifdef WS2812_DIM_EN
   localparam logic [23:0] EXP_A = 24'h29003F;
   localparam logic [23:0] EXP_C = 24'h203F00;
   localparam logic [23:0] EXP_B [4] = '{24'h00300C, 24'h00300C, 24'h00300C, 24'h00300C};
`else
   localparam logic [23:0] EXP_A = 24'hA500FF;
   localparam logic [23:0] EXP_C = 24'h80FF03;
   localparam logic [23:0] EXP_B [4] = '{24'h00C030, 24'h01C131, 24'h02C232, 24'h03C333};
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       update_frame = 1'b0;
   logic [7:0] g, r, b;
   logic [1:0] current_led;
   logic       data_out, busy, frame_done;
   int         n_chk = 0, n_err = 0;

   ws2812_serializer #(
      .MAX_POS(MAX_POS), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .BIT_CYCLES(BITC),
      .LATCH_CYCLES(LATCH), .LOOKUP_CYCLES(LOOKUP), .DIM_SHIFT(2)
   ) dut (
      .clk(clk), .reset(reset), .update_frame(update_frame),
      .led_green_intensity(g), .led_red_intensity(r), .led_blue_intensity(b),
      .current_led(current_led), .data_out(data_out), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Core model: intensities follow current_led with two clocks of latency
   int         mode = 0;
   logic [1:0] idx_d1 = '0, idx_d2 = '0;
   always @(posedge clk) begin
      idx_d1 <= current_led;
      idx_d2 <= idx_d1;
   end
   always_comb begin
      g = 8'hA5; r = 8'h00; b = 8'hFF;
      if (mode == 1) begin
         g = {6'd0, idx_d2}; r = 8'hC0 + {6'd0, idx_d2}; b = 8'h30 + {6'd0, idx_d2};
      end else if (mode == 2) begin
         g = 8'h80; r = 8'hFF; b = 8'h03;
      end
   end

   // Line decoder
   int   cyc = 0, since_rise = 0, hi = 0, bad_width = 0, bad_period = 0;
   int   done_cnt = 0, start_cyc = 0, busy_gap = 0;
   bit   in_frame = 0, watch_busy = 0;
   logic prev_d = 1'b0;
   logic [1:0] prev_led = '0;
   bit   bits[$];
   int   flen[$], done_at[$], led_seq[$];

   always @(negedge clk) begin
      cyc++;
      since_rise++;
      if (data_out && !prev_d) begin
         if (in_frame && since_rise != BITC) bad_period++;
         if (!in_frame) begin
            in_frame  = 1;
            start_cyc = cyc;
         end
         since_rise = 0;
         hi = 0;
      end
      if (data_out) hi++;
      if (!data_out && prev_d) begin
         if (hi == T1H) bits.push_back(1'b1);
         else if (hi == T0H) bits.push_back(1'b0);
         else bad_width++;
      end
      if (frame_done) begin
         flen.push_back(cyc - start_cyc);
         done_at.push_back(cyc);
         done_cnt++;
         in_frame = 0;
      end
      if (current_led != prev_led) led_seq.push_back(int'(current_led));
      if (watch_busy && !busy && !frame_done) busy_gap++;
      prev_d   = data_out;
      prev_led = current_led;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      bits.delete(); flen.delete(); done_at.delete(); led_seq.delete();
      bad_width = 0; bad_period = 0; done_cnt = 0; busy_gap = 0; in_frame = 0;
      since_rise = 0; hi = 0;
      prev_d = data_out; prev_led = current_led;
   endtask

   function automatic int word_at(input int led);
      logic [23:0] w = '0;
      for (int i = 0; i < 24; i++)
         if (24 * led + i < bits.size()) w = {w[22:0], bits[24 * led + i]};
      return int'(w);
   endfunction

   task automatic pulse();
      @(negedge clk); update_frame = 1'b1;
      @(negedge clk); update_frame = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge clk); #1; n++;
      end
      if (done_cnt < target) chk("timeout_frame_done", done_cnt, target);
   endtask

   task automatic settle();
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int odd;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data_out", data_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_current_led", current_led, 0);
      @(negedge clk); reset = 1'b0;
      repeat (3) settle();
      chk("idle_busy", busy, 0);

      // A: constant colour, single pulse
      mode = 0; settle(); clear_mon();
      pulse();
      wait_done(1, 800);
      chk("A_nbits", bits.size(), 96);
      for (int k = 0; k < MAX_POS; k++) chk($sformatf("A_word%0d", k), word_at(k), int'(EXP_A));
      chk("A_bad_width", bad_width, 0);
      chk("A_bad_period", bad_period, 0);
      chk("A_frame_len", flen.size() > 0 ? flen[0] : -1, FRAME_LEN);
      chk("A_done_cnt", done_cnt, 1);
      chk("A_busy_after", busy, 0);
      chk("A_done_one_clk", frame_done, 0);

      // B: index-dependent colour, prefetch and current_led walk
      mode = 1; settle(); clear_mon();
      pulse();
      wait_done(1, 800);
      for (int k = 0; k < MAX_POS; k++) chk($sformatf("B_word%0d", k), word_at(k), int'(EXP_B[k]));
      chk("B_led_seq_len", led_seq.size(), 4);
      for (int i = 0; i < 4 && i < led_seq.size(); i++)
         chk($sformatf("B_led_seq%0d", i), led_seq[i], (i + 1) % 4);
      chk("B_frame_len", flen.size() > 0 ? flen[0] : -1, FRAME_LEN);
      chk("B_bad_period", bad_period, 0);

      // C: three requests during a frame collapse into one extra frame
      mode = 0; settle(); clear_mon();
      pulse();
      watch_busy = 1;
      repeat (50) @(posedge clk);
      pulse();
      repeat (200) @(posedge clk);
      pulse();
      repeat (200) @(posedge clk);
      pulse();
      wait_done(2, 1500);
      watch_busy = 0;
      chk("C_done_cnt", done_cnt, 2);
      chk("C_busy_gap", busy_gap, 0);
      chk("C_done_gap", done_at.size() > 1 ? done_at[1] - done_at[0] : -1, DONE_GAP);
      repeat (700) @(posedge clk);
      #1;
      chk("C_no_third", done_cnt, 2);
      chk("C_busy_end", busy, 0);
      chk("C_nbits", bits.size(), 192);

      // D: update_frame held high. The level is still high in the first LOAD cycle after the
      // third frame_done, so it registers as pending: frames 4 and 5 follow, then idle.
      settle(); clear_mon();
      @(negedge clk); update_frame = 1'b1;
      settle();
      watch_busy = 1;
      wait_done(3, 2500);
      update_frame = 1'b0;
      wait_done(5, 1500);
      watch_busy = 0;
      chk("D_busy_gap", busy_gap, 0);
      for (int i = 1; i < 5; i++)
         chk($sformatf("D_done_gap%0d", i), done_at.size() > i ? done_at[i] - done_at[i-1] : -1, DONE_GAP);
      odd = 0;
      foreach (flen[i]) if (flen[i] != FRAME_LEN) odd++;
      chk("D_frame_lens", odd, 0);
      repeat (700) @(posedge clk);
      #1;
      chk("D_done_cnt", done_cnt, 5);
      chk("D_nbits", bits.size(), 5 * 96);
      chk("D_bad_period", bad_period, 0);

      // Reset asserted while data_out is high mid-frame
      mode = 0; settle(); clear_mon();
      pulse();
      repeat (30) @(posedge clk);
      odd = 0;
      while (!data_out && odd < 20) begin
         @(posedge clk); #2; odd++;
      end
      chk("R_high_before", data_out, 1);
      reset = 1'b1;
      #1;
      chk("R_data_out", data_out, 0);
      chk("R_busy", busy, 0);
      chk("R_frame_done", frame_done, 0);
      chk("R_current_led", current_led, 0);
      @(negedge clk); reset = 1'b0;
      repeat (20) settle();
      chk("R_idle_busy", busy, 0);
      chk("R_idle_data", data_out, 0);

      // Dim configuration: R=FF, G=80, B=03
      mode = 2; settle(); clear_mon();
      pulse();
      wait_done(1, 800);
      chk("DIM_word0", word_at(0), int'(EXP_C));
      chk("DIM_word3", word_at(3), int'(EXP_C));
      chk("DIM_nbits", bits.size(), 96);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
